// File: rtl/fu_sequencer_pkg.sv
// fu_sequencer_pkg: opcode constants shared by the sequencer and the FU benches,
// plus the illegal-opcode decode used when FU_SEQ_ILLEGAL_EN is defined.
package fu_sequencer_pkg;

  localparam logic [5:0] OP_INC = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h02;
  localparam logic [5:0] OP_LT  = 6'h0E;
  localparam logic [5:0] OP_EQ  = 6'h1E;

  // Holes in the functional_unit opcode map.
  function automatic logic fu_op_illegal(input logic [5:0] op);
    case (op) inside
      6'h04, 6'h06, 6'h07, 6'h0B, 6'h0C, 6'h26, 6'h27,
      [6'h29:6'h2F], [6'h35:6'h37]: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fu_seq_fifo.sv
// fu_seq_fifo: synchronous FIFO with occupancy count, async active-high reset.
// Ports: clk, rst, push/push_data (write), pop/pop_data (head, registered
// storage), count (entries held, 0..DEPTH).
// Pop is ignored while empty; push+pop while full keeps the count unchanged.
module fu_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        do_pop;

  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit logic must make overflow impossible.
  always @(posedge clk)
    if (!rst) assert (!(push && (count == CW'(DEPTH)) && !pop));

endmodule

// File: rtl/fu_sequencer.sv
// fu_sequencer: issues requests to functional_unit one per cycle and returns
// Z/COMPARE tagged and in order.
// Ports: CLOCK/RESET (async, active high); REQ_* valid/ready request channel;
// FU_A/B/C/INST/SELECT to the FU, FU_Z/FU_COMPARE from it; RSP_* valid/ready
// response channel (RSP_ERR only meaningful with FU_SEQ_ILLEGAL_EN).
// Config macro: FU_SEQ_ILLEGAL_EN -- flag holes in the opcode map; flagged ops
// still issue but respond with Z=0, COMPARE=0, ERR=1.
import fu_sequencer_pkg::*;

module fu_sequencer #(
  parameter int FU_LATENCY = 1,
  parameter int RSP_DEPTH  = 4,
  parameter int TAG_W      = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [5:0]       REQ_INST,
  input  logic [31:0]      REQ_A,
  input  logic [31:0]      REQ_B,
  input  logic [31:0]      REQ_C,
  input  logic             REQ_SELECT,
  input  logic [TAG_W-1:0] REQ_TAG,
  output logic [31:0]      FU_A,
  output logic [31:0]      FU_B,
  output logic [31:0]      FU_C,
  output logic [5:0]       FU_INST,
  output logic             FU_SELECT,
  input  logic [31:0]      FU_Z,
  input  logic             FU_COMPARE,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [31:0]      RSP_Z,
  output logic             RSP_COMPARE,
  output logic [TAG_W-1:0] RSP_TAG,
  output logic             RSP_ERR
);

  localparam int L  = FU_LATENCY;
  localparam int CW = $clog2(RSP_DEPTH + 1);
`ifdef FU_SEQ_ILLEGAL_EN
  localparam int DW = 32 + 1 + TAG_W + 1;
`else
  localparam int DW = 32 + 1 + TAG_W;
`endif

  logic                      rdy_en;     // holds REQ_READY low for the first cycle out of reset
  logic                      accept;
  logic [L:0]                vld_pipe;   // stage k = op issued k edges ago
  logic [L:0][TAG_W-1:0]     tag_pipe;
  logic [DW-1:0]             push_d, pop_d;
  logic [CW-1:0]             fifo_cnt;

  assign accept = REQ_VALID && REQ_READY;

  // Issue register and in-flight tracking. Idle slots drive all-zero (INC A=0),
  // whose results are simply not captured since the stage valid is 0.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rdy_en    <= 1'b0;
      FU_A      <= '0;
      FU_B      <= '0;
      FU_C      <= '0;
      FU_INST   <= '0;
      FU_SELECT <= 1'b0;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
    end else begin
      rdy_en    <= 1'b1;
      FU_A      <= accept ? REQ_A      : '0;
      FU_B      <= accept ? REQ_B      : '0;
      FU_C      <= accept ? REQ_C      : '0;
      FU_INST   <= accept ? REQ_INST   : '0;
      FU_SELECT <= accept ? REQ_SELECT : 1'b0;
      vld_pipe[0] <= accept;
      tag_pipe[0] <= accept ? REQ_TAG : '0;
      for (int i = 1; i <= L; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Credit: every in-flight op already owns a FIFO slot, so the FIFO can never
  // overflow. Uses registered state only; a same-cycle pop frees credit next cycle.
  always_comb begin
    int n;
    n = int'(fifo_cnt);
    for (int i = 0; i <= L; i++) n += int'(vld_pipe[i]);
    REQ_READY = rdy_en && (n < RSP_DEPTH);
  end

`ifdef FU_SEQ_ILLEGAL_EN
  logic [L:0] err_pipe;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) err_pipe <= '0;
    else begin
      err_pipe[0] <= accept && fu_op_illegal(REQ_INST);
      for (int i = 1; i <= L; i++) err_pipe[i] <= err_pipe[i-1];
    end
  end

  assign push_d = err_pipe[L] ? {32'd0, 1'b0, tag_pipe[L], 1'b1}
                              : {FU_Z, FU_COMPARE, tag_pipe[L], 1'b0};
  assign {RSP_Z, RSP_COMPARE, RSP_TAG, RSP_ERR} = pop_d;
`else
  assign push_d  = {FU_Z, FU_COMPARE, tag_pipe[L]};
  assign {RSP_Z, RSP_COMPARE, RSP_TAG} = pop_d;
  assign RSP_ERR = 1'b0;
`endif

  fu_seq_fifo #(.WIDTH(DW), .DEPTH(RSP_DEPTH), .CW(CW)) u_rsp_fifo (
    .clk       (CLOCK),
    .rst       (RESET),
    .push      (vld_pipe[L]),
    .push_data (push_d),
    .pop       (RSP_VALID && RSP_READY),
    .pop_data  (pop_d),
    .count     (fifo_cnt)
  );

  assign RSP_VALID = (fifo_cnt != '0);

endmodule

// File: tb/tb_fu_sequencer.sv
// tb_fu_sequencer: directed vectors with a queue scoreboard. A behavioural
// functional_unit (1-cycle latency) sits on the FU pins.
import fu_sequencer_pkg::*;

module tb_fu_sequencer;

  logic        CLOCK, RESET;
  logic        REQ_VALID, REQ_READY, REQ_SELECT;
  logic [5:0]  REQ_INST;
  logic [31:0] REQ_A, REQ_B, REQ_C;
  logic [3:0]  REQ_TAG;
  logic [31:0] FU_A, FU_B, FU_C;
  logic [5:0]  FU_INST;
  logic        FU_SELECT;
  logic [31:0] FU_Z;
  logic        FU_COMPARE;
  logic        RSP_VALID, RSP_READY, RSP_COMPARE, RSP_ERR;
  logic [31:0] RSP_Z;
  logic [3:0]  RSP_TAG;

  fu_sequencer dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_INST(REQ_INST),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_C(REQ_C), .REQ_SELECT(REQ_SELECT), .REQ_TAG(REQ_TAG),
    .FU_A(FU_A), .FU_B(FU_B), .FU_C(FU_C), .FU_INST(FU_INST), .FU_SELECT(FU_SELECT),
    .FU_Z(FU_Z), .FU_COMPARE(FU_COMPARE),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_Z(RSP_Z),
    .RSP_COMPARE(RSP_COMPARE), .RSP_TAG(RSP_TAG), .RSP_ERR(RSP_ERR)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Functional unit stand-in: samples its pins on the rising edge, result valid after it.
  always @(posedge CLOCK) begin
    case (FU_INST)
      OP_INC:  begin FU_Z <= FU_A + 32'd1; FU_COMPARE <= 1'b0; end
      OP_ADD:  begin FU_Z <= FU_A + FU_B;  FU_COMPARE <= 1'b0; end
      OP_LT:   begin FU_Z <= FU_A - FU_B;  FU_COMPARE <= ($signed(FU_A) < $signed(FU_B)); end
      OP_EQ:   begin FU_Z <= FU_A - FU_B;  FU_COMPARE <= (FU_A == FU_B); end
      default: begin FU_Z <= FU_A ^ FU_B;  FU_COMPARE <= 1'b0; end
    endcase
  end

  typedef struct {
    logic [31:0] z;
    logic        cmp;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compares every handshaken response against the scoreboard head,
  // and checks that a stalled response holds still.
  logic        hold_v = 1'b0;
  logic [31:0] hold_z;
  logic [3:0]  hold_tag;

  always @(negedge CLOCK) begin
    if (!RESET && RSP_VALID) begin
      if (hold_v) begin
        chk("rsp_hold_z", RSP_Z, hold_z);
        chk("rsp_hold_tag", {28'd0, RSP_TAG}, {28'd0, hold_tag});
      end
      if (RSP_READY) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got tag %h z %h, expected no response", RSP_TAG, RSP_Z);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_tag", {28'd0, RSP_TAG}, {28'd0, e.tag});
          chk("rsp_z", RSP_Z, e.z);
          chk("rsp_compare", {31'd0, RSP_COMPARE}, {31'd0, e.cmp});
          chk("rsp_err", {31'd0, RSP_ERR}, {31'd0, e.err});
        end
      end else begin
        hold_v   = 1'b1;
        hold_z   = RSP_Z;
        hold_tag = RSP_TAG;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Present one request, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [5:0] inst, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] ez, input logic ecmp,
                      input logic eerr, output int waited);
    exp_t e;
    REQ_VALID = 1'b1; REQ_INST = inst; REQ_A = a; REQ_B = b; REQ_C = 32'd0;
    REQ_SELECT = 1'b0; REQ_TAG = tag;
    waited = 0;
    forever begin
      @(negedge CLOCK);
      if (REQ_READY) break;
      waited++;
      if (waited > 50) begin
        n_chk++; n_fail++;
        $display("FAIL req_accept_timeout: got REQ_READY 0 for 50 cycles, expected 1");
        break;
      end
    end
    if (waited <= 50) begin
      e.z = ez; e.cmp = ecmp; e.tag = tag; e.err = eerr;
      exp_q.push_back(e);
    end
    @(posedge CLOCK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge CLOCK);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge CLOCK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, acc;
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_INST = '0; REQ_A = '0; REQ_B = '0; REQ_C = '0;
    REQ_SELECT = 1'b0; REQ_TAG = '0; RSP_READY = 1'b1;

    // Reset state
    repeat (3) @(posedge CLOCK);
    #1;
    chk("reset_req_ready", {31'd0, REQ_READY}, 32'd0);
    chk("reset_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("reset_fu_a", FU_A, 32'd0);
    chk("reset_fu_inst", {26'd0, FU_INST}, 32'd0);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("req_ready_release", {31'd0, REQ_READY}, 32'd0);
    @(negedge CLOCK);
    chk("req_ready_after_1", {31'd0, REQ_READY}, 32'd1);
    @(posedge CLOCK); #1;

    // 1: single ADD, response two cycles after accept
    send(OP_ADD, 32'd5, 32'd7, 4'd3, 32'h0000000C, 1'b0, 1'b0, w);
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("lat_e1_valid", {31'd0, RSP_VALID}, 32'd0);
    @(negedge CLOCK);
    chk("lat_e2_valid", {31'd0, RSP_VALID}, 32'd1);
    drain();

    // 2: back-to-back ops, never stalled
    send(OP_ADD, 32'd1,  32'd2,  4'd1, 32'd3,         1'b0, 1'b0, w); chk("b2b_wait0", w, 0);
    send(OP_ADD, 32'd10, 32'd20, 4'd2, 32'd30,        1'b0, 1'b0, w); chk("b2b_wait1", w, 0);
    send(OP_INC, 32'd9,  32'd0,  4'd4, 32'd10,        1'b0, 1'b0, w); chk("b2b_wait2", w, 0);
    send(OP_LT,  32'd3,  32'd5,  4'd5, 32'hFFFFFFFE,  1'b1, 1'b0, w); chk("b2b_wait3", w, 0);
    drain();

    // 3: consumer stalled, exactly RSP_DEPTH accepted
    RSP_READY = 1'b0;
    acc = 0;
    REQ_VALID = 1'b1; REQ_INST = OP_ADD;
    for (int cyc = 0; cyc < 10; cyc++) begin
      REQ_A = acc + 1; REQ_B = acc + 1; REQ_TAG = 4'(8 + acc);
      @(negedge CLOCK);
      if (REQ_READY) begin
        exp_t e;
        e.z = 32'(2 * (acc + 1)); e.cmp = 1'b0; e.tag = 4'(8 + acc); e.err = 1'b0;
        exp_q.push_back(e);
        acc++;
      end
      @(posedge CLOCK); #1;
    end
    REQ_VALID = 1'b0;
    chk("full_accept_count", acc, 4);
    @(negedge CLOCK);
    chk("full_req_ready", {31'd0, REQ_READY}, 32'd0);
    @(posedge CLOCK); #1;
    RSP_READY = 1'b1;
    drain();

    // 4: compare ops
    send(OP_LT, 32'hFFFFFFFF, 32'd0,      4'd6, 32'hFFFFFFFF, 1'b1, 1'b0, w);
    send(OP_EQ, 32'h1234,     32'h1234,   4'd7, 32'd0,        1'b1, 1'b0, w);
    drain();

    // 5: reset with 2 in flight and 1 queued
    RSP_READY = 1'b0;
    send(OP_ADD, 32'd1, 32'd1, 4'd1, 32'd2, 1'b0, 1'b0, w);
    send(OP_ADD, 32'd2, 32'd2, 4'd2, 32'd4, 1'b0, 1'b0, w);
    send(OP_ADD, 32'd3, 32'd3, 4'd3, 32'd6, 1'b0, 1'b0, w);
    #1 RESET = 1'b1;
    #1;
    chk("midreset_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("midreset_req_ready", {31'd0, REQ_READY}, 32'd0);
    chk("midreset_fu_a", FU_A, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    RSP_READY = 1'b1;
    @(negedge CLOCK);
    chk("post_reset_ready0", {31'd0, REQ_READY}, 32'd0);
    @(negedge CLOCK);
    chk("post_reset_ready1", {31'd0, REQ_READY}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK);
      chk("post_reset_no_rsp", {31'd0, RSP_VALID}, 32'd0);
    end
    @(posedge CLOCK); #1;

    // 6: opcode 04 (hole in the opcode map); stand-in FU returns A^B
`ifdef FU_SEQ_ILLEGAL_EN
    send(6'h04, 32'd5, 32'd3, 4'd9, 32'd0, 1'b0, 1'b1, w);
`else
    send(6'h04, 32'd5, 32'd3, 4'd9, 32'd6, 1'b0, 1'b0, w);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
